// File: rtl/min_receive_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : min_receive_fsm_if
// Description : Bundle of the byte-input and frame-output signals of the MIN
//               receive deframer.
//               master modport : byte source / frame consumer side
//               slave  modport : deframer side
// Signals     : i_en      clock enable
//               i_valid   one-cycle strobe, i_data holds a received byte
//               i_data    received byte
//               o_id      ID byte of the last good frame
//               o_len     payload length of the last good frame
//               o_data    payload of the last good frame, first byte at MSB
//               o_valid   one-cycle pulse, new good frame
//               o_err     one-cycle pulse, frame discarded
//               o_busy    deframer is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
interface min_receive_fsm_if #(
   parameter int N_DATA_BYTE = 8
);
   logic                     i_en;
   logic                     i_valid;
   logic [7:0]               i_data;
   logic [7:0]               o_id;
   logic [7:0]               o_len;
   logic [8*N_DATA_BYTE-1:0] o_data;
   logic                     o_valid;
   logic                     o_err;
   logic                     o_busy;

   modport master (
      output i_en, i_valid, i_data,
      input  o_id, o_len, o_data, o_valid, o_err, o_busy
   );

   modport slave (
      input  i_en, i_valid, i_data,
      output o_id, o_len, o_data, o_valid, o_err, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/min_receive_fsm.sv
`default_nettype none
// ============================================================================
// Module      : min_receive_fsm
// Description : MIN frame receiver/deframer. Finds the AA AA AA header,
//               removes stuff bytes, captures ID, LEN and payload, checks
//               CRC-32 and the 0x55 EOF byte, and presents each good frame
//               as one parallel word with a one-cycle o_valid strobe.
// Ports       : i_clk   system clock
//               i_rst   asynchronous active-high reset
//               bus     min_receive_fsm_if.slave (byte input, frame output)
// Revision    : 1.0 - initial release
// ============================================================================
module min_receive_fsm #(
   parameter int N_DATA_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   min_receive_fsm_if.slave   bus
);

   localparam int          c_W    = 8 * N_DATA_BYTE;
   localparam logic [31:0] c_POLY = 32'hEDB8_8320;

   localparam logic [3:0] c_SOF     = 4'd0;
   localparam logic [3:0] c_ID      = 4'd1;
   localparam logic [3:0] c_LEN     = 4'd2;
   localparam logic [3:0] c_PAYLOAD = 4'd3;
   localparam logic [3:0] c_CRC0    = 4'd4;
   localparam logic [3:0] c_CRC1    = 4'd5;
   localparam logic [3:0] c_CRC2    = 4'd6;
   localparam logic [3:0] c_CRC3    = 4'd7;
   localparam logic [3:0] c_EOF     = 4'd8;

   // One byte of reflected CRC-32 (running register, no final XOR).
   function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ c_POLY) : (r >> 1);
      end
      return r;
   endfunction

   logic [3:0]     state_q,   state_d;
   logic [1:0]     aa_cnt_q,  aa_cnt_d;
   logic [31:0]    crc_q,     crc_d;
   logic [31:0]    rx_crc_q,  rx_crc_d;
   logic [7:0]     id_buf_q,  id_buf_d;
   logic [7:0]     len_buf_q, len_buf_d;
   logic [c_W-1:0] buf_q,     buf_d;
   logic [7:0]     cnt_q,     cnt_d;
   logic [7:0]     id_q,      id_d;
   logic [7:0]     len_q,     len_d;
   logic [c_W-1:0] data_q,    data_d;
   logic           valid_q,   valid_d;
   logic           err_q,     err_d;

   logic           w_accept;
   logic           w_is_aa;
   logic [7:0]     w_byte;
   logic [c_W-1:0] w_top;

   assign w_accept = bus.i_en && bus.i_valid;
   assign w_byte   = bus.i_data;
   assign w_is_aa  = (bus.i_data == 8'hAA);

   // Incoming byte placed in the top lane; shifted down by the byte index.
   always_comb begin
      w_top              = '0;
      w_top[c_W-1 -: 8]  = w_byte;
   end

   always_comb begin
      state_d   = state_q;
      aa_cnt_d  = aa_cnt_q;
      crc_d     = crc_q;
      rx_crc_d  = rx_crc_q;
      id_buf_d  = id_buf_q;
      len_buf_d = len_buf_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      len_d     = len_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      if (w_accept) begin
         if (w_is_aa && (aa_cnt_q == 2'd2)) begin
            // Third AA: (re)start a frame; any partial frame is dropped
            // silently.
            state_d  = c_ID;
            aa_cnt_d = 2'd0;
            crc_d    = 32'hFFFF_FFFF;
            buf_d    = '0;
            cnt_d    = 8'd0;
         end else if ((aa_cnt_q == 2'd2) && (state_q != c_SOF)) begin
            // Byte after two data AAs must be a stuff 0x55; it carries no
            // data and does not touch the CRC.
            aa_cnt_d = 2'd0;
            if (w_byte != 8'h55) begin
               err_d   = 1'b1;
               state_d = c_SOF;
            end
         end else begin
            aa_cnt_d = w_is_aa ? (aa_cnt_q + 2'd1) : 2'd0;
            case (state_q)
               c_ID: begin
                  id_buf_d = w_byte;
                  crc_d    = crc32_byte(crc_q, w_byte);
                  state_d  = c_LEN;
               end
               c_LEN: begin
                  if (32'(w_byte) > 32'(N_DATA_BYTE)) begin
                     err_d   = 1'b1;
                     state_d = c_SOF;
                  end else begin
                     len_buf_d = w_byte;
                     crc_d     = crc32_byte(crc_q, w_byte);
                     cnt_d     = 8'd0;
                     state_d   = (w_byte == 8'd0) ? c_CRC0 : c_PAYLOAD;
                  end
               end
               c_PAYLOAD: begin
                  buf_d = buf_q | (w_top >> {cnt_q, 3'b000});
                  crc_d = crc32_byte(crc_q, w_byte);
                  cnt_d = cnt_q + 8'd1;
                  if ((cnt_q + 8'd1) == len_buf_q) begin
                     state_d = c_CRC0;
                  end
               end
               c_CRC0, c_CRC1, c_CRC2, c_CRC3: begin
                  rx_crc_d = {rx_crc_q[23:0], w_byte};
                  state_d  = state_q + 4'd1;
               end
               c_EOF: begin
                  if ((w_byte == 8'h55) && (rx_crc_q == ~crc_q)) begin
                     id_d    = id_buf_q;
                     len_d   = len_buf_q;
                     data_d  = buf_q;
                     valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = c_SOF;
               end
               default: begin
                  state_d = c_SOF;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= c_SOF;
         aa_cnt_q  <= 2'd0;
         crc_q     <= 32'hFFFF_FFFF;
         rx_crc_q  <= 32'h0;
         id_buf_q  <= 8'h0;
         len_buf_q <= 8'h0;
         buf_q     <= '0;
         cnt_q     <= 8'd0;
         id_q      <= 8'h0;
         len_q     <= 8'h0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         aa_cnt_q  <= aa_cnt_d;
         crc_q     <= crc_d;
         rx_crc_q  <= rx_crc_d;
         id_buf_q  <= id_buf_d;
         len_buf_q <= len_buf_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         len_q     <= len_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign bus.o_id    = id_q;
   assign bus.o_len   = len_q;
   assign bus.o_data  = data_q;
   assign bus.o_valid = valid_q;
   assign bus.o_err   = err_q;
   assign bus.o_busy  = (state_q != c_SOF);

endmodule
`default_nettype wire

// File: tb/tb_min_receive_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_min_receive_fsm
// Description : Self-checking bench for min_receive_fsm. Frames are built
//               from ID/payload with a byte-level CRC-32 and stuffing
//               encoder; the expected outcome of each frame (good/discarded)
//               and the held output word are tracked at frame level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_min_receive_fsm;

   localparam int N = 8;
   localparam int W = 8 * N;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   min_receive_fsm_if #(.N_DATA_BYTE(N)) bus ();

   min_receive_fsm #(.N_DATA_BYTE(N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errs   = 0;

   // Frame-level reference: outputs of the last good frame.
   logic [7:0]   m_id;
   logic [7:0]   m_len;
   logic [W-1:0] m_data;

   int   seen_valid = 0;
   int   seen_err   = 0;
   logic last_valid;
   logic last_err;

   task automatic check_val(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] crc32(input bq_t q);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB8_8320 : 32'h0);
      end
      return ~c;
   endfunction

   // Transmit-side stuffing: after every second consecutive AA insert 55.
   function automatic bq_t stuff(input bq_t q);
      bq_t o;
      int  run;
      run = 0;
      foreach (q[i]) begin
         o.push_back(q[i]);
         if (q[i] == 8'hAA) begin
            run++;
            if (run == 2) begin
               o.push_back(8'h55);
               run = 0;
            end
         end else begin
            run = 0;
         end
      end
      return o;
   endfunction

   function automatic bq_t build(input logic [7:0] id, input bq_t pl,
                                 input logic [31:0] crc_xor, input logic [7:0] eof);
      bq_t body, enc, o;
      logic [31:0] c;
      body.push_back(id);
      body.push_back(8'(pl.size()));
      foreach (pl[i]) body.push_back(pl[i]);
      c = crc32(body) ^ crc_xor;
      body.push_back(c[31:24]);
      body.push_back(c[23:16]);
      body.push_back(c[15:8]);
      body.push_back(c[7:0]);
      enc = stuff(body);
      o.push_back(8'hAA); o.push_back(8'hAA); o.push_back(8'hAA);
      foreach (enc[i]) o.push_back(enc[i]);
      o.push_back(eof);
      return o;
   endfunction

   function automatic logic [W-1:0] pack(input bq_t p);
      logic [W-1:0] d;
      d = '0;
      foreach (p[i]) d[W-1-8*i -: 8] = p[i];
      return d;
   endfunction

   function automatic bq_t rand_payload(input int len);
      bq_t p;
      int  r;
      for (int i = 0; i < len; i++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      p.push_back(8'hAA);
         else if (r == 1) p.push_back(8'h55);
         else             p.push_back(8'($urandom));
      end
      return p;
   endfunction

   task automatic sample();
      last_valid = bus.o_valid;
      last_err   = bus.o_err;
      if (bus.o_valid) seen_valid++;
      if (bus.o_err)   seen_err++;
      if (bus.o_valid || bus.o_err) check_val("valid_err_exclusive", bus.o_valid & bus.o_err, 0);
   endtask

   task automatic drive(input logic e, input logic v, input logic [7:0] b);
      @(negedge clk);
      sample();
      bus.i_en    = e;
      bus.i_valid = v;
      bus.i_data  = b;
   endtask

   task automatic send(input bq_t q);
      foreach (q[i]) drive(1'b1, 1'b1, q[i]);
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 8'h00);
   endtask

   task automatic expect_good(input logic [7:0] id, input bq_t pl);
      m_id   = id;
      m_len  = 8'(pl.size());
      m_data = pack(pl);
   endtask

   task automatic check_frame(input string tag, input int ev, input int ee);
      check_val({tag, "_nvalid"}, 64'(seen_valid), 64'(ev));
      check_val({tag, "_nerr"},   64'(seen_err),   64'(ee));
      check_val({tag, "_id"},     64'(bus.o_id),   64'(m_id));
      check_val({tag, "_len"},    64'(bus.o_len),  64'(m_len));
      check_val({tag, "_data"},   64'(bus.o_data), 64'(m_data));
      check_val({tag, "_busy"},   64'(bus.o_busy), 64'(0));
      seen_valid = 0;
      seen_err   = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t pl, q, q2;
      int  kind, len, pos;

      bus.i_en    = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = 8'h00;
      rst         = 1'b1;
      m_id = 8'h0; m_len = 8'h0; m_data = '0;
      #13;
      check_val("rst_id",    64'(bus.o_id),    0);
      check_val("rst_len",   64'(bus.o_len),   0);
      check_val("rst_data",  64'(bus.o_data),  0);
      check_val("rst_valid", 64'(bus.o_valid), 0);
      check_val("rst_err",   64'(bus.o_err),   0);
      check_val("rst_busy",  64'(bus.o_busy),  0);
      @(negedge clk);
      rst = 1'b0;

      // Basic good frame and one-cycle latency.
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send(build(8'h01, pl, 32'h0, 8'h55));
      idle();
      check_val("t1_latency", 64'(last_valid), 1);
      expect_good(8'h01, pl);
      idle();
      check_val("t1_data_const", 64'(bus.o_data), 64'h0102030405060708);
      check_frame("t1", 1, 0);

      // Payload requiring stuffing.
      pl = '{8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
      send(build(8'h01, pl, 32'h0, 8'h55));
      idle();
      expect_good(8'h01, pl);
      check_val("t2_data_const", 64'(bus.o_data), 64'hAAAA55AA00000000);
      check_frame("t2", 1, 0);

      // CRC bit flip, then wrong EOF: discarded, outputs retained.
      send(build(8'h01, pl, 32'h0000_0100, 8'h55));
      idle();
      check_val("t3_crc_err_pulse", 64'(last_err), 1);
      check_frame("t3_crc", 0, 1);
      send(build(8'h01, pl, 32'h0, 8'h56));
      idle();
      check_frame("t3_eof", 0, 1);

      // Oversized LEN, immediately followed by a good frame.
      q  = '{8'hAA, 8'hAA, 8'hAA, 8'h03, 8'h09};
      pl = '{8'h10, 8'h20, 8'h30};
      q2 = build(8'h04, pl, 32'h0, 8'h55);
      send(q);
      drive(1'b1, 1'b1, q2[0]);
      check_val("t4_len_err", 64'(last_err), 1);
      q2.delete(0);
      send(q2);
      idle();
      expect_good(8'h04, pl);
      check_frame("t4", 1, 1);

      // Header injected mid-payload restarts the frame silently.
      send('{8'hAA, 8'hAA, 8'hAA, 8'h05, 8'h08, 8'h11, 8'h22, 8'h33});
      pl = '{8'hBE, 8'hEF};
      send(build(8'h02, pl, 32'h0, 8'h55));
      idle();
      expect_good(8'h02, pl);
      check_val("t5_data_const", 64'(bus.o_data), 64'hBEEF000000000000);
      check_frame("t5", 1, 0);

      // i_en low mid-frame: strobes (even a header) are ignored.
      pl = rand_payload(5);
      q  = build(8'h07, pl, 32'h0, 8'h55);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, q[i]);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'hAA);
      drive(1'b0, 1'b1, 8'h00);
      check_val("t6_busy_hold", 64'(bus.o_busy), 1);
      for (int i = 7; i < q.size(); i++) drive(1'b1, 1'b1, q[i]);
      idle();
      expect_good(8'h07, pl);
      check_frame("t6", 1, 0);
      // Whole frame with i_en low: nothing happens.
      q = build(8'h09, rand_payload(4), 32'h0, 8'h55);
      foreach (q[i]) drive(1'b0, 1'b1, q[i]);
      idle();
      check_frame("t6_en0", 0, 0);

      // Asynchronous reset mid-payload.
      q = build(8'h0A, rand_payload(8), 32'h0, 8'h55);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, q[i]);
      drive(1'b1, 1'b0, 8'h00);
      #2 rst = 1'b1;
      #1;
      check_val("t7_rst_id",   64'(bus.o_id),   0);
      check_val("t7_rst_len",  64'(bus.o_len),  0);
      check_val("t7_rst_data", 64'(bus.o_data), 0);
      check_val("t7_rst_busy", 64'(bus.o_busy), 0);
      #3 rst = 1'b0;
      m_id = 8'h0; m_len = 8'h0; m_data = '0;
      seen_valid = 0; seen_err = 0;
      pl = rand_payload(6);
      send(build(8'h0B, pl, 32'h0, 8'h55));
      idle();
      expect_good(8'h0B, pl);
      check_frame("t7", 1, 0);

      // Back-to-back frames, no gap.
      pl = rand_payload(3);
      q  = build(8'h21, pl, 32'h0, 8'h55);
      send(q);
      pl = rand_payload(7);
      send(build(8'h22, pl, 32'h0, 8'h55));
      idle();
      expect_good(8'h22, pl);
      check_frame("t8", 2, 0);

      // Randomized frames with random corruption.
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 5);
         len  = $urandom_range(0, N);
         pl   = rand_payload(len);
         q.delete();
         case (kind)
            1: q = build(8'($urandom), pl, 32'h1 << $urandom_range(0, 31), 8'h55);
            2: q = build(8'($urandom), pl, 32'h0, 8'($urandom_range(0, 254)) ^ 8'h55 ^ 8'h55 | 8'h01 & 8'hFF);
            3: begin
               q = '{8'hAA, 8'hAA, 8'hAA};
               q2 = stuff('{8'($urandom), 8'($urandom_range(N + 1, 255))});
               foreach (q2[i]) q.push_back(q2[i]);
            end
            4: begin
               q = build(8'($urandom), pl, 32'h0, 8'h55);
               pos = -1;
               for (int i = 5; i < q.size() - 1; i++)
                  if (pos < 0 && q[i-2] == 8'hAA && q[i-1] == 8'hAA && q[i] == 8'h55) pos = i;
               if (pos >= 0) q[pos] = 8'h12;
               else q = build(8'($urandom), pl, 32'h8000_0000, 8'h55);
            end
            default: q = build(8'($urandom), pl, 32'h0, 8'h55);
         endcase
         if (kind == 2 && q[q.size()-1] == 8'h55) q[q.size()-1] = 8'h54;
         send(q);
         idle();
         if (kind == 0 || kind == 5) begin
            expect_good(q[3], pl);
            check_frame("rand_good", 1, 0);
         end else begin
            check_frame("rand_bad", 0, 1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/min_receive_fsm.md
Name: min_receive_fsm

Overview:
- Byte-level receiver and deframer for MIN frames arriving from the UART receive path; the inverse of the on-board MIN transmit framer.
- Finds the header, removes stuff bytes, captures ID, length and payload, and checks CRC32 and EOF.
- Emits each valid frame as a single parallel word with a one-cycle strobe. Used for host-to-board commands such as calibration, trigger and parameter writes.

Parameters:
- N_DATA_BYTE, 8: maximum payload bytes; sets the o_data width to 8*N_DATA_BYTE.

Ports:
- i_clk  in  1  system clock (sclk domain).
- i_rst  in  1  reset.
- i_en  in  1  clock enable; when low, all state holds and input bytes are ignored.
- i_valid  in  1  one-cycle strobe: i_data holds a received UART byte.
- i_data  in  8  received byte.
- o_id  out  8  ID/control byte of the last good frame.
- o_len  out  8  payload length of the last good frame.
- o_data  out  8*N_DATA_BYTE  payload of the last good frame. First received byte is in [8N-1:8N-8]; unused low bytes are zero.
- o_valid  out  1  one-cycle pulse: new good frame on o_id/o_len/o_data.
- o_err  out  1  one-cycle pulse: frame discarded.
- o_busy  out  1  high while the FSM is inside a frame (any state except SOF).

Behaviour:
- Reset is asynchronous, active-high, one clock, as already decided; the interface uses i_clk and i_rst. Reset values: o_id=0, o_len=0, o_data=0, o_valid=0, o_err=0, o_busy=0; state=SOF; header count=0; CRC=0xFFFFFFFF.
- Bytes are processed only on cycles where i_en && i_valid. Outputs are registered.
- Frame format on the wire: AA AA AA, ID, LEN, payload[LEN], CRC[31:24], CRC[23:16], CRC[15:8], CRC[7:0], 55.
- CRC definition: CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Computed over ID, LEN and payload after unstuffing.
- Header detection:
  - A consecutive-0xAA counter (0..3) runs in every state; any non-0xAA byte clears it.
  - On the third consecutive 0xAA: go to ID, reset CRC, clear the payload buffer, counter to 0.
  - This applies mid-frame: the partial frame is abandoned silently, with no o_err.
- Stuffing:
  - After the header, two consecutive 0xAA bytes followed by 0x55 means the 0x55 is a stuff byte. It is dropped with no state or CRC update, and the counter clears.
  - Two 0xAA followed by any byte other than 0x55 or 0xAA: o_err pulse, go to SOF.
- State transitions (per accepted, unstuffed byte):
  - SOF → ID only via header detection.
  - ID: latch the ID → LEN.
  - LEN: if LEN > N_DATA_BYTE, o_err pulse → SOF. Else latch LEN → PAYLOAD, or → CRC0 if LEN=0.
  - PAYLOAD: store bytes MSB-first; byte counter increments; after LEN bytes → CRC0.
  - CRC0..CRC3: shift the received CRC in MSB first → EOF.
  - EOF:
    - Byte==0x55 and received CRC == computed CRC: latch outputs, o_valid pulse the following cycle.
    - Otherwise: o_err pulse, outputs unchanged.
    - Either way → SOF.
- Latency: o_valid asserts exactly one i_clk after the cycle that accepts the EOF byte.
- o_id, o_len and o_data hold their values until the next good frame.
- o_valid and o_err are never high in the same cycle.
- Back-to-back frames with no gap must be accepted.

Test Plan:
- Good frame: ID=0x01, LEN=8, payload 01..08, correct CRC from the bench model, EOF 55 → o_valid one cycle after EOF, o_id=01, o_len=08, o_data=0x0102030405060708.
- Stuffed payload AA AA 55 AA 00 00 00 00 (wire AA AA 55 55 AA 00…), LEN=8 → o_data=0xAAAA55AA00000000, o_valid=1, o_err=0.
- Same frame with one CRC bit flipped → o_err pulse, o_valid=0, outputs retain the previous frame. Wrong EOF (0x56) → o_err.
- LEN=9 with N_DATA_BYTE=8 → o_err on the LEN byte; the next good frame sent immediately after is accepted.
- Header AA AA AA injected after 3 payload bytes, followed by a full good frame (ID=0x02, LEN=2, payload BEEF) → no o_err, o_valid, o_data=0xBEEF000000000000.
- Assert i_rst asynchronously mid-PAYLOAD → all outputs 0 immediately, o_busy=0; the next good frame decodes correctly. Hold i_en=0 during i_valid strobes → no state change.
